router_pkt_framer: RTL and testbench

Store-and-forward packet source sitting directly upstream of the 1x3 router's source port. It accepts a destination/length request and a payload byte stream, and buffers the payload while computing parity. It then drives the router-format packet (header, payload, parity) onto the router input, honouring router busy and capturing the router's parity error for that packet.

---
 rtl/router_pkt_framer.sv | 199 +++++++++++++++++++
 tb/tb_router_pkt_framer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_framer.sv
// ----------------------------------------------------------------------------
// router_pkt_framer
//
// Store-and-forward packet source feeding the source port of the 1x3 router.
// A request (destination + length) is accepted, the payload bytes are loaded
// into a 64x8 buffer while a running XOR parity is built, and the packet is
// then played out in router format: header {len, addr}, payload bytes, parity.
// The router busy input stalls the outgoing byte stream without skipping or
// repeating any byte. After the parity byte the framer watches rtr_error for
// CHECK_CYCLES cycles, then pulses done with pkt_err reporting whether the
// router flagged a parity error for this packet.
//
// Parameters
//   CHECK_CYCLES   cycles spent in CHECK after parity is consumed (1..15)
//
// Ports
//   clock          rising-edge clock
//   reset          asynchronous, active-high reset
//   req_valid      packet request strobe
//   req_addr[1:0]  destination port, 0..2 legal
//   req_len[5:0]   payload length in bytes, 1..63 legal
//   req_ready      framer idle; request taken on req_valid & req_ready
//   req_reject     one-cycle pulse when an illegal request is dropped
//   pay_data[7:0]  payload byte
//   pay_valid      payload byte valid
//   pay_ready      framer loading; byte taken on pay_valid & pay_ready
//   rtr_data[7:0]  byte presented to router data_in (registered)
//   rtr_pkt_valid  router pkt_valid (registered)
//   rtr_busy       router busy; current byte is held while high
//   rtr_error      router parity error indication
//   done           one-cycle pulse when the packet is closed
//   pkt_err        router error seen for the last packet; valid with done
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | waiting for a request; illegal requests pulse req_reject
// LOAD    | writing payload bytes into the buffer, accumulating parity
// HEADER  | header byte presented, waiting for router to take it
// PAYLOAD | payload byte presented; send_idx points at the next one
// PARITY  | parity byte presented with pkt_valid low
// CHECK   | post-packet window sampling rtr_error before done
// ----------------------------------------------------------------------------
module router_pkt_framer #(
  parameter int CHECK_CYCLES = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [1:0] req_addr,
  input  logic [5:0] req_len,
  output logic       req_ready,
  output logic       req_reject,
  input  logic [7:0] pay_data,
  input  logic       pay_valid,
  output logic       pay_ready,
  output logic [7:0] rtr_data,
  output logic       rtr_pkt_valid,
  input  logic       rtr_busy,
  input  logic       rtr_error,
  output logic       done,
  output logic       pkt_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    HEADER  = 3'd2,
    PAYLOAD = 3'd3,
    PARITY  = 3'd4,
    CHECK   = 3'd5
  } state_t;

  localparam logic [3:0] CHK_LAST = 4'(CHECK_CYCLES - 1);

  state_t     state;
  logic [1:0] addr_q;
  logic [5:0] len_q;
  logic [5:0] load_cnt;
  logic [5:0] send_idx;
  logic [3:0] chk_cnt;
  logic [7:0] parity;

  logic [7:0] buffer [0:63];

  logic       load_wr;
  logic       req_illegal;

  assign req_ready   = (state == IDLE);
  assign pay_ready   = (state == LOAD);
  assign load_wr     = (state == LOAD) && pay_valid;
  assign req_illegal = (req_addr == 2'd3) || (req_len == 6'd0);

  // Payload storage carries no reset: contents are only read after being
  // written for the current packet.
  always_ff @(posedge clock) begin
    if (load_wr) begin
      buffer[load_cnt] <= pay_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      rtr_data      <= 8'h00;
      rtr_pkt_valid <= 1'b0;
      done          <= 1'b0;
      req_reject    <= 1'b0;
      pkt_err       <= 1'b0;
      addr_q        <= 2'd0;
      len_q         <= 6'd0;
      load_cnt      <= 6'd0;
      send_idx      <= 6'd0;
      chk_cnt       <= 4'd0;
      parity        <= 8'h00;
    end else begin
      done       <= 1'b0;
      req_reject <= 1'b0;

      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_illegal) begin
              req_reject <= 1'b1;
            end else begin
              addr_q   <= req_addr;
              len_q    <= req_len;
              parity   <= {req_len, req_addr};
              load_cnt <= 6'd0;
              pkt_err  <= 1'b0;
              state    <= LOAD;
            end
          end
        end

        LOAD: begin
          if (pay_valid) begin
            parity   <= parity ^ pay_data;
            load_cnt <= load_cnt + 6'd1;
            if (load_cnt == len_q - 6'd1) begin
              rtr_data      <= {len_q, addr_q};
              rtr_pkt_valid <= 1'b1;
              state         <= HEADER;
            end
          end
        end

        HEADER: begin
          if (!rtr_busy) begin
            rtr_data <= buffer[0];
            send_idx <= 6'd1;
            state    <= PAYLOAD;
          end
        end

        PAYLOAD: begin
          // send_idx == len_q means the last payload byte is the one being
          // consumed now, so the parity byte goes out next.
          if (!rtr_busy) begin
            if (send_idx == len_q) begin
              rtr_data      <= parity;
              rtr_pkt_valid <= 1'b0;
              state         <= PARITY;
            end else begin
              rtr_data <= buffer[send_idx];
              send_idx <= send_idx + 6'd1;
            end
          end
        end

        PARITY: begin
          if (rtr_error) begin
            pkt_err <= 1'b1;
          end
          if (!rtr_busy) begin
            rtr_data <= 8'h00;
            chk_cnt  <= 4'd0;
            state    <= CHECK;
          end
        end

        CHECK: begin
          if (rtr_error) begin
            pkt_err <= 1'b1;
          end
          chk_cnt <= chk_cnt + 4'd1;
          if (chk_cnt == CHK_LAST) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_router_pkt_framer.sv
module tb_router_pkt_framer;

  localparam int CC = 3;

  logic       clock;
  logic       reset;
  logic       req_valid;
  logic [1:0] req_addr;
  logic [5:0] req_len;
  logic       req_ready;
  logic       req_reject;
  logic [7:0] pay_data;
  logic       pay_valid;
  logic       pay_ready;
  logic [7:0] rtr_data;
  logic       rtr_pkt_valid;
  logic       rtr_busy;
  logic       rtr_error;
  logic       done;
  logic       pkt_err;

  int n_checks = 0;
  int n_errors = 0;
  int edge_cnt = 0;

  logic [7:0] pay_mem [0:63];

  router_pkt_framer #(.CHECK_CYCLES(CC)) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_len       (req_len),
    .req_ready     (req_ready),
    .req_reject    (req_reject),
    .pay_data      (pay_data),
    .pay_valid     (pay_valid),
    .pay_ready     (pay_ready),
    .rtr_data      (rtr_data),
    .rtr_pkt_valid (rtr_pkt_valid),
    .rtr_busy      (rtr_busy),
    .rtr_error     (rtr_error),
    .done          (done),
    .pkt_err       (pkt_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    edge_cnt++;
  endtask

  task automatic set_basic();
    pay_mem[0] = 8'h11;
    pay_mem[1] = 8'h22;
    pay_mem[2] = 8'h33;
    pay_mem[3] = 8'h44;
  endtask

  // Drives one full packet starting in a cycle where the framer is idle and
  // returns in the cycle where done is expected high.
  task automatic send_packet(input logic [1:0] addr, input logic [5:0] len,
                             input logic [7:0] hdr, input logic [7:0] par,
                             input int busy_idx, input int busy_n,
                             input int gap_idx, input int gap_n,
                             input int err_cyc, input logic exp_err);
    logic [7:0] exp_seq [0:65];
    int base;
    int n;
    n = int'(len);
    exp_seq[0] = hdr;
    for (int i = 0; i < n; i++) exp_seq[i+1] = pay_mem[i];
    exp_seq[n+1] = par;

    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_addr  = addr;
    req_len   = len;
    step();
    base      = edge_cnt;
    req_valid = 1'b0;
    check("pkt_err_clr", pkt_err, 0);
    check("pay_ready_load", pay_ready, 1);
    check("rtr_valid_load", rtr_pkt_valid, 0);

    for (int i = 0; i < n; i++) begin
      if (i == gap_idx) begin
        pay_valid = 1'b0;
        repeat (gap_n) step();
      end
      pay_valid = 1'b1;
      pay_data  = pay_mem[i];
      step();
    end
    pay_valid = 1'b0;
    pay_data  = 8'h00;
    check("pay_ready_off", pay_ready, 0);

    for (int k = 0; k <= n + 1; k++) begin
      check($sformatf("rtr_data[%0d]", k), rtr_data, exp_seq[k]);
      check($sformatf("rtr_valid[%0d]", k), rtr_pkt_valid, (k <= n));
      if (k == busy_idx) begin
        rtr_busy = 1'b1;
        repeat (busy_n) begin
          step();
          check($sformatf("hold_data[%0d]", k), rtr_data, exp_seq[k]);
          check($sformatf("hold_valid[%0d]", k), rtr_pkt_valid, (k <= n));
        end
        rtr_busy = 1'b0;
      end
      step();
    end
    check("rtr_data_post", rtr_data, 0);
    check("rtr_valid_post", rtr_pkt_valid, 0);

    for (int c = 0; c < CC; c++) begin
      check("done_early", done, 0);
      rtr_error = (c == err_cyc);
      step();
    end
    rtr_error = 1'b0;
    check("done", done, 1);
    check("pkt_err_done", pkt_err, exp_err);
    check("done_edge", edge_cnt - base, 2*n + 2 + CC + busy_n + gap_n);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = 2'd0;
    req_len   = 6'd0;
    pay_data  = 8'h00;
    pay_valid = 1'b0;
    rtr_busy  = 1'b0;
    rtr_error = 1'b0;
    #12;
    check("rst_data", rtr_data, 0);
    check("rst_valid", rtr_pkt_valid, 0);
    check("rst_done", done, 0);
    check("rst_reject", req_reject, 0);
    check("rst_pkt_err", pkt_err, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_pay_ready", pay_ready, 0);
    reset = 1'b0;
    step();

    // Basic packet: addr 1, len 4 -> header 0x11, parity 0x55, done at edge 13
    set_basic();
    send_packet(2'd1, 6'd4, 8'h11, 8'h55, -1, 0, -1, 0, -1, 1'b0);
    step();
    check("done_pulse", done, 0);

    // Same packet, router busy for 3 cycles while 0x22 is presented
    send_packet(2'd1, 6'd4, 8'h11, 8'h55, 2, 3, -1, 0, -1, 1'b0);
    step();
    check("done_pulse_busy", done, 0);

    // Illegal requests
    req_valid = 1'b1; req_addr = 2'd3; req_len = 6'd5;
    step();
    req_valid = 1'b0;
    check("rej_addr3", req_reject, 1);
    check("rej_addr3_pay_ready", pay_ready, 0);
    check("rej_addr3_valid", rtr_pkt_valid, 0);
    check("rej_addr3_idle", req_ready, 1);
    step();
    check("rej_addr3_pulse", req_reject, 0);
    req_valid = 1'b1; req_addr = 2'd0; req_len = 6'd0;
    step();
    req_valid = 1'b0;
    check("rej_len0", req_reject, 1);
    check("rej_len0_pay_ready", pay_ready, 0);
    check("rej_len0_valid", rtr_pkt_valid, 0);
    step();
    check("rej_len0_pulse", req_reject, 0);
    check("rej_len0_pay_ready2", pay_ready, 0);

    // Router error two cycles after parity: addr 0, len 2, A5 0F
    pay_mem[0] = 8'hA5;
    pay_mem[1] = 8'h0F;
    send_packet(2'd0, 6'd2, 8'h08, 8'hA2, -1, 0, -1, 0, 1, 1'b1);
    step();
    check("pkt_err_sticky", pkt_err, 1);
    // Next accepted request clears pkt_err; payload gap of 2 cycles
    set_basic();
    send_packet(2'd1, 6'd4, 8'h11, 8'h55, -1, 0, 2, 2, -1, 1'b0);
    step();

    // Reset mid-LOAD
    req_valid = 1'b1; req_addr = 2'd1; req_len = 6'd4;
    step();
    req_valid = 1'b0;
    pay_valid = 1'b1; pay_data = 8'h11;
    step();
    pay_data = 8'h22;
    step();
    pay_valid = 1'b0;
    check("mid_load_pay_ready", pay_ready, 1);
    #2 reset = 1'b1;
    #1;
    check("rstL_data", rtr_data, 0);
    check("rstL_valid", rtr_pkt_valid, 0);
    check("rstL_done", done, 0);
    check("rstL_pkt_err", pkt_err, 0);
    check("rstL_req_ready", req_ready, 1);
    check("rstL_pay_ready", pay_ready, 0);
    #1 reset = 1'b0;
    step();
    send_packet(2'd1, 6'd4, 8'h11, 8'h55, -1, 0, -1, 0, -1, 1'b0);
    step();

    // Reset mid-PAYLOAD
    req_valid = 1'b1; req_addr = 2'd1; req_len = 6'd4;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pay_valid = 1'b1;
      pay_data  = pay_mem[i];
      step();
    end
    pay_valid = 1'b0;
    step();
    step();
    check("mid_pay_data", rtr_data, 8'h22);
    check("mid_pay_valid", rtr_pkt_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("rstP_data", rtr_data, 0);
    check("rstP_valid", rtr_pkt_valid, 0);
    check("rstP_done", done, 0);
    check("rstP_reject", req_reject, 0);
    check("rstP_pkt_err", pkt_err, 0);
    check("rstP_req_ready", req_ready, 1);
    #1 reset = 1'b0;
    step();

    // Max length, incrementing payload 1..63: header 0xFE, parity 0xFE
    for (int i = 0; i < 63; i++) pay_mem[i] = 8'(i + 1);
    send_packet(2'd2, 6'd63, 8'hFE, 8'hFE, -1, 0, -1, 0, -1, 1'b0);
    // Back-to-back request issued in the done cycle
    set_basic();
    send_packet(2'd1, 6'd4, 8'h11, 8'h55, -1, 0, -1, 0, -1, 1'b0);
    step();
    check("final_done_pulse", done, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
